sprite_capture: RTL and testbench
=================================

Name: sprite_capture

Overview:
- Inverse of the 16x16 sprite renderer: deserializes the renderer's 1-bit gfx pixel stream back into the 32-byte bitmap layout used by the tank bitmap ROM (two bytes per row, low byte first).
- Undoes h/v mirroring, so a capture of a rotated-and-mirrored tank must equal the source bitmap.
- Sits beside tank_controller in test/debug tops; a checker or LED/UART dumper reads the result through a ROM-style read port.

Parameters:
- HSTART_LAT, 2, cycles from an accepted hstart pulse to gfx carrying pixel x=0 (renderer: 1 cycle state change + 1 cycle registered gfx).
- ROWS, 16, sprite rows captured per frame; fixed at 16 for this layout.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- arm  in  1  one-cycle pulse: capture the next sprite frame
- vstart  in  1  sprite top-line pulse (same signal fed to the renderer)
- hstart  in  1  sprite left-edge pulse (same signal fed to the renderer)
- gfx  in  1  serial pixel stream from the renderer
- hmirror  in  1  mirror flag in effect for this sprite; sampled at every row store
- vmirror  in  1  as hmirror, for rows
- rd_addr  in  5  {row[3:0], byte_sel}
- rd_bits  out  8  registered read data
- busy  out  1  high in ARMED/WAIT_H/DELAY/SHIFT/STORE
- done  out  1  capture complete, buffer valid
- overrun  out  1  sticky: vstart arrived while a frame was partially captured
- pix_count  out  9  number of set pixels in the last completed capture (0..256)

Behaviour:
- Reset: state=IDLE; rd_bits, busy, done, overrun, pix_count, row, xcnt=0. The 32-byte buffer is not reset.
- States:
  - IDLE: arm -> ARMED; clear done and overrun; zero the running pixel count.
  - ARMED: vstart -> WAIT_H with row=0.
  - WAIT_H: hstart -> DELAY, load delay counter with HSTART_LAT-1. If HSTART_LAT=1, go straight to SHIFT.
  - DELAY: count down to 0 -> SHIFT with xcnt=0.
  - SHIFT: each cycle shift gfx into a 16-bit row register at bit (hmirror ? ~xcnt : xcnt); xcnt++; add gfx to the running count. At xcnt==15 (pre-increment) -> STORE.
  - STORE: write row register to buffer row (vmirror ? ~row : row), bits[7:0] to byte 0 and bits[15:8] to byte 1, in one cycle. If row==15: pix_count<=running count, done<=1 -> IDLE. Else row++ -> WAIT_H.
- Pixel count per row is exactly 16 samples; gfx outside SHIFT is ignored.
- hstart in DELAY/SHIFT/STORE is ignored.
- vstart in WAIT_H/DELAY/SHIFT/STORE when row!=0 or a SHIFT is in progress:
  - set overrun, discard the partial frame, row=0, running count=0, go to WAIT_H.
  - vstart while in WAIT_H with row==0 is harmless; stay in WAIT_H.
- arm outside IDLE is ignored. arm in IDLE while done=1 starts a new capture and clears done.
- Read port:
  - rd_bits <= buf[rd_addr] every cycle, 1-cycle latency.
  - Legal in any state; data is stale or partial unless done=1.
  - A read of the row being written in STORE returns the old byte.
- Mid-operation reset returns to IDLE immediately; the buffer keeps its partial contents.
- Timing: for back-to-back rows, STORE (1 cycle) plus WAIT_H must complete before the next hstart. This is guaranteed because hstart recurs once per scanline.

Decomposition:
- Shared package (sprite_pkg): SPRITE_W=16, SPRITE_H=16, BYTES_PER_ROW=2, ROM_ADDR_W=5, capture state encoding localparams.
- One natural sub-module: sprite_capture_ram, a 32x8 synchronous RAM with a 16-bit row write (byte pair) and an 8-bit registered read. It is reusable as a RAM variant of the tank bitmap ROM.

Test Plan:
- Bitmap 0 rows from the renderer, hmirror=vmirror=0, HSTART_LAT=2 -> buffer equals ROM bitmap 0 bytes; e.g. row0 byte0=8'h80, byte1=8'h07; done=1 after the 16th STORE; pix_count equals the popcount of bitmap 0.
- Rotation 9 (bitmap 1, hmirror=vmirror=1) -> captured buffer equals unmirrored bitmap 1; rd_addr=5'h03 returns 8'h1E one cycle later.
- gfx forced to 1 for all 16 rows -> all 32 bytes 8'hFF; pix_count=256 (9'h100, no wrap).
- vstart injected after row 5 STORE -> overrun=1, capture restarts at row 0, final done=1 with a correct buffer from the second frame.
- arm pulsed while busy, and hstart pulsed during SHIFT -> no state change; capture result unchanged versus the clean run.
- reset asserted mid-SHIFT of row 7 -> next cycle busy=0, done=0, pix_count=0, state IDLE; a fresh arm then captures a correct frame.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite capture path: bitmap geometry and
// capture FSM state encoding.
package sprite_pkg;

   localparam int SPRITE_W      = 16;
   localparam int SPRITE_H      = 16;
   localparam int BYTES_PER_ROW = 2;
   localparam int ROM_ADDR_W    = 5;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARMED  = 3'd1;
   localparam logic [2:0] ST_WAIT_H = 3'd2;
   localparam logic [2:0] ST_DELAY  = 3'd3;
   localparam logic [2:0] ST_SHIFT  = 3'd4;
   localparam logic [2:0] ST_STORE  = 3'd5;

   // Mirrored index within a 16-entry axis: 15-idx is simply the bitwise inverse.
   function automatic logic [3:0] mirror_idx(input logic [3:0] idx, input logic mir);
      return mir ? ~idx : idx;
   endfunction

endpackage

// File: rtl/sprite_capture_ram.sv
// 32x8 synchronous RAM: one 16-bit row write (low byte at even address)
// and a registered 8-bit read. Usable as a writable stand-in for the bitmap ROM.
module sprite_capture_ram
   import sprite_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [3:0]            wr_row,
   input  logic [SPRITE_W-1:0]   wr_data,
   input  logic [ROM_ADDR_W-1:0] rd_addr,
   output logic [7:0]            rd_data
);

   logic [7:0] mem_r [0:(1 << ROM_ADDR_W)-1];

   // Row write: both bytes of a row land in the same cycle; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[{wr_row, 1'b0}] <= wr_data[7:0];
         mem_r[{wr_row, 1'b1}] <= wr_data[15:8];
      end
   end

   // Registered read; a same-cycle write to the addressed byte returns the old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= 8'h00;
      end else begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/sprite_capture.sv
// Deserializes the sprite renderer's gfx stream back into the 32-byte
// bitmap layout, undoing h/v mirroring, and exposes it on a ROM-style read port.
module sprite_capture
   import sprite_pkg::*;
#(
   parameter int HSTART_LAT = 2,
   parameter int ROWS       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  vstart,
   input  logic                  hstart,
   input  logic                  gfx,
   input  logic                  hmirror,
   input  logic                  vmirror,
   input  logic [ROM_ADDR_W-1:0] rd_addr,
   output logic [7:0]            rd_bits,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun,
   output logic [8:0]            pix_count
);

   logic [2:0]          state_r,     state_s;
   logic [3:0]          row_r,       row_s;
   logic [3:0]          xcnt_r,      xcnt_s;
   logic [3:0]          dly_r,       dly_s;
   logic [SPRITE_W-1:0] shreg_r,     shreg_s;
   logic [8:0]          run_cnt_r,   run_cnt_s;
   logic [8:0]          pix_count_r, pix_count_s;
   logic                done_r,      done_s;
   logic                overrun_r,   overrun_s;
   logic                busy_r;
   logic                wr_en_s;
   logic                restart_s;

   // Next-state and datapath decode for the capture FSM.
   always_comb begin
      state_s     = state_r;
      row_s       = row_r;
      xcnt_s      = xcnt_r;
      dly_s       = dly_r;
      shreg_s     = shreg_r;
      run_cnt_s   = run_cnt_r;
      pix_count_s = pix_count_r;
      done_s      = done_r;
      overrun_s   = overrun_r;
      wr_en_s     = 1'b0;

      // A vstart once a row capture has begun means the frame is torn: start over.
      restart_s = vstart
                  && (state_r inside {ST_WAIT_H, ST_DELAY, ST_SHIFT, ST_STORE})
                  && !((state_r == ST_WAIT_H) && (row_r == 4'd0));

      if (restart_s) begin
         overrun_s = 1'b1;
         row_s     = 4'd0;
         xcnt_s    = 4'd0;
         run_cnt_s = 9'd0;
         state_s   = ST_WAIT_H;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (arm) begin
                  state_s   = ST_ARMED;
                  done_s    = 1'b0;
                  overrun_s = 1'b0;
                  run_cnt_s = 9'd0;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (vstart) begin
                  state_s = ST_WAIT_H;
                  row_s   = 4'd0;
               end else begin
                  state_s = ST_ARMED;
               end
            end
            ST_WAIT_H: begin
               if (hstart) begin
                  xcnt_s = 4'd0;
                  if (HSTART_LAT <= 1) begin
                     state_s = ST_SHIFT;
                  end else begin
                     state_s = ST_DELAY;
                     dly_s   = 4'(HSTART_LAT - 1);
                  end
               end else begin
                  state_s = ST_WAIT_H;
               end
            end
            ST_DELAY: begin
               if (dly_r <= 4'd1) begin
                  state_s = ST_SHIFT;
                  xcnt_s  = 4'd0;
                  dly_s   = 4'd0;
               end else begin
                  dly_s = dly_r - 4'd1;
               end
            end
            ST_SHIFT: begin
               shreg_s[mirror_idx(xcnt_r, hmirror)] = gfx;
               run_cnt_s = run_cnt_r + {8'd0, gfx};
               xcnt_s    = xcnt_r + 4'd1;
               if (xcnt_r == 4'd15) begin
                  state_s = ST_STORE;
               end else begin
                  state_s = ST_SHIFT;
               end
            end
            ST_STORE: begin
               wr_en_s = 1'b1;
               if (row_r == 4'(ROWS - 1)) begin
                  pix_count_s = run_cnt_r;
                  done_s      = 1'b1;
                  state_s     = ST_IDLE;
               end else begin
                  row_s   = row_r + 4'd1;
                  state_s = ST_WAIT_H;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; the bitmap buffer itself is not reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         row_r       <= 4'd0;
         xcnt_r      <= 4'd0;
         dly_r       <= 4'd0;
         shreg_r     <= '0;
         run_cnt_r   <= 9'd0;
         pix_count_r <= 9'd0;
         done_r      <= 1'b0;
         overrun_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         row_r       <= row_s;
         xcnt_r      <= xcnt_s;
         dly_r       <= dly_s;
         shreg_r     <= shreg_s;
         run_cnt_r   <= run_cnt_s;
         pix_count_r <= pix_count_s;
         done_r      <= done_s;
         overrun_r   <= overrun_s;
         busy_r      <= (state_s != ST_IDLE);
      end
   end

   sprite_capture_ram u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_s),
      .wr_row  (mirror_idx(row_r, vmirror)),
      .wr_data (shreg_r),
      .rd_addr (rd_addr),
      .rd_data (rd_bits)
   );

   assign busy      = busy_r;
   assign done      = done_r;
   assign overrun   = overrun_r;
   assign pix_count = pix_count_r;

endmodule

// File: tb/tb_sprite_capture.sv
// Bench for sprite_capture: a behavioural renderer streams bitmaps with
// mirroring; captured bytes are checked against the source bitmaps.
module tb_sprite_capture;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       arm = 1'b0, vstart = 1'b0, hstart = 1'b0, gfx = 1'b0;
   logic       hmirror = 1'b0, vmirror = 1'b0;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_bits;
   logic       busy, done, overrun;
   logic [8:0] pix_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] rom0 [32];
   logic [7:0] rom1 [32];
   logic [7:0] src  [32];
   logic [7:0] exp_q [$];
   bit         cur_ones;

   typedef struct {
      int bm;
      bit hm;
      bit vm;
      bit ones;
   } vec_t;
   vec_t vecs [4];

   always #5 clk = ~clk;

   sprite_capture #(.HSTART_LAT(2), .ROWS(16)) dut (
      .clk(clk), .reset(reset), .arm(arm), .vstart(vstart), .hstart(hstart),
      .gfx(gfx), .hmirror(hmirror), .vmirror(vmirror), .rd_addr(rd_addr),
      .rd_bits(rd_bits), .busy(busy), .done(done), .overrun(overrun),
      .pix_count(pix_count)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic load_src(input int bm);
      for (int i = 0; i < 32; i++) src[i] = (bm == 0) ? rom0[i] : rom1[i];
   endtask

   // Renderer model: screen row r shows bitmap row (vm ? 15-r : r), pixel x shows bit (hm ? 15-x : x).
   function automatic logic pixel(input int r, input int x, input bit hm, input bit vm);
      logic [15:0] word;
      int sr;
      sr = vm ? 15 - r : r;
      word = {src[2*sr+1], src[2*sr]};
      if (cur_ones) return 1'b1;
      return hm ? word[15-x] : word[x];
   endfunction

   function automatic int popcount_exp();
      int n = 0;
      for (int i = 0; i < 32; i++)
         for (int b = 0; b < 8; b++) n += cur_ones ? 1 : int'(src[i][b]);
      return n;
   endfunction

   task automatic do_arm();
      @(negedge clk); arm = 1'b1;
      @(negedge clk); arm = 1'b0;
      check("arm_busy", busy, 1);
      check("arm_done_clr", done, 0);
   endtask

   task automatic render(input bit hm, input bit vm, input bit do_vs, input int nrows,
                         input int glitch_row);
      hmirror = hm; vmirror = vm;
      if (do_vs) begin
         @(negedge clk); vstart = 1'b1;
         @(negedge clk); vstart = 1'b0;
      end
      for (int r = 0; r < nrows; r++) begin
         @(negedge clk); hstart = 1'b1;
         @(negedge clk); hstart = 1'b0;
         for (int x = 0; x < 16; x++) begin
            @(negedge clk);
            gfx = pixel(r, x, hm, vm);
            if (r == glitch_row) begin
               hstart = (x == 5);
               arm    = (x == 8);
            end
         end
         @(negedge clk); gfx = 1'b0; hstart = 1'b0; arm = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic verify(input string tag, input bit exp_ovr);
      int n;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_overrun"}, overrun, exp_ovr);
      check({tag, "_pix"}, pix_count, popcount_exp());
      for (int a = 0; a <= 32; a++) begin
         @(negedge clk);
         if (exp_q.size() > 0) check({tag, "_byte"}, rd_bits, exp_q.pop_front());
         if (a < 32) begin
            rd_addr = 5'(a);
            exp_q.push_back(cur_ones ? 8'hFF : src[a]);
         end
      end
   endtask

   initial begin
      rom0 = '{8'h80,8'h07, 8'h80,8'h0F, 8'hC0,8'h1F, 8'hE0,8'h3F, 8'hF0,8'h7E, 8'h38,8'hFC,
               8'h1C,8'hF8, 8'h0E,8'hF0, 8'h07,8'hE0, 8'h03,8'hC0, 8'h81,8'h81, 8'hC3,8'h42,
               8'h66,8'h24, 8'h3C,8'h18, 8'h18,8'h00, 8'h00,8'h01};
      rom1 = '{8'h00,8'h00, 8'h01,8'h1E, 8'h03,8'h3F, 8'h07,8'h7F, 8'h0F,8'hFF, 8'h1F,8'hF0,
               8'h3E,8'hE0, 8'h7C,8'hC0, 8'hF8,8'h80, 8'hF0,8'h01, 8'hE0,8'h03, 8'hC0,8'h07,
               8'h80,8'h0F, 8'h55,8'hAA, 8'hAA,8'h55, 8'h12,8'h34};
      vecs[0] = '{0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1, 1'b0, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_rd_bits", rd_bits, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_pix", pix_count, 0);

      for (int v = 0; v < 4; v++) begin
         load_src(vecs[v].bm);
         cur_ones = vecs[v].ones;
         do_arm();
         render(vecs[v].hm, vecs[v].vm, 1'b1, 16, -1);
         verify($sformatf("vec%0d", v), 1'b0);
      end

      // arm and hstart pulsed in the middle of row 3's SHIFT must be ignored
      cur_ones = 1'b0;
      load_src(0);
      do_arm();
      render(1'b0, 1'b0, 1'b1, 16, 3);
      verify("glitch", 1'b0);

      // torn frame: six rows of bitmap 1, then a new vstart and a full bitmap 0 frame
      do_arm();
      load_src(1);
      render(1'b1, 1'b1, 1'b1, 6, -1);
      load_src(0);
      render(1'b0, 1'b0, 1'b1, 16, -1);
      verify("overrun", 1'b1);

      // reset in the middle of row 7's SHIFT
      load_src(1);
      do_arm();
      render(1'b0, 1'b0, 1'b1, 7, -1);
      @(negedge clk); hstart = 1'b1;
      @(negedge clk); hstart = 1'b0;
      for (int x = 0; x < 4; x++) begin
         @(negedge clk); gfx = pixel(7, x, 1'b0, 1'b0);
      end
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_pix", pix_count, 0);
      check("midrst_overrun", overrun, 0);
      reset = 1'b0; gfx = 1'b0;
      @(negedge clk);
      check("midrst_idle", busy, 0);
      do_arm();
      render(1'b0, 1'b0, 1'b1, 16, -1);
      verify("after_rst", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
